uart_hex_printer: RTL and testbench
===================================

Name: uart_hex_printer

Overview:
Parametrised successor to the fixed print top. It accepts DATA_W-bit words into an internal FIFO, renders each word as uppercase ASCII hex digits (MSB nibble first), terminates each word with CR LF, and serialises the characters over an 8N1 UART transmitter. Firmware or logic blocks on the 100 MHz domain use it as a debug console. An 8-bit debug display output shows internal state.

Parameters:
BAUD_PER, 868, clock cycles per UART bit (115200 baud at 100 MHz); must be >= 2
DATA_W, 32, input word width; must be a multiple of 4 and >= 4
FIFO_DEPTH, 8, word FIFO depth; must be a power of 2 and >= 2

Ports:
clk_100MHz  input  1  system clock
rst_i  input  1  asynchronous active-high reset
data_i  input  DATA_W  word to print
valid_i  input  1  word-valid strobe
ready_o  output  1  FIFO not full; a push occurs when valid_i && ready_o
uarttx_ser_o  output  1  UART serial output; idles high
busy_o  output  1  FIFO non-empty or printer not IDLE
overflow_o  output  1  sticky flag: valid_i was seen while ready_o was low
dbg_sel_i  input  4  debug display select
dbg_disp_o  output  8  debug display value

Behaviour:
- Reset: one clock, reset is asynchronous and active-high. Reset clears the FIFO to empty and puts the FSM in IDLE. Output reset values: uarttx_ser_o=1, ready_o=1, busy_o=0, overflow_o=0, dbg_disp_o=0x00. Asserting reset mid-frame drives the line high immediately and discards all queued words.
- FIFO:
  - count is registered; ready_o = (count != FIFO_DEPTH).
  - A push and a pop in the same cycle leave count unchanged.
  - A push attempted while full is dropped and sets overflow_o, which clears only on reset.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head word into the shift register, set the digit index to DATA_W/4-1, and go to LOAD.
  - LOAD: select the current character into the tx byte, then go to START.
  - START: drive the line low for BAUD_PER cycles, then go to DATA.
  - DATA: send 8 bits LSB first, BAUD_PER cycles each, then go to STOP.
  - STOP: drive the line high for BAUD_PER cycles, then go to NEXT.
  - NEXT (1 cycle):
    - If hex digits remain, decrement the index and go to LOAD.
    - Otherwise the sequence continues: CR (0x0D) after the last digit, LF (0x0A) after CR.
    - After LF, go to IDLE.
- Digit mapping: nibble 0-9 maps to 0x30-0x39, nibble A-F maps to 0x41-0x46. Leading zeros are always printed.
- Timing:
  - A word pushed at clock edge k into an empty FIFO with the FSM idle has its start bit begin at edge k+3 (k+1 visible in FIFO, k+2 popped, k+3 START).
  - Each character occupies 10*BAUD_PER + 2 cycles (LOAD + NEXT overhead).
  - A back-to-back word starts via IDLE with 1 extra cycle.
- Baud counter: counts 0..BAUD_PER-1 and wraps, restarting at every state entry. A bit counter 0..7 is used in DATA.
- Words-printed counter: 8 bits, increments when LF completes, wraps 0xFF -> 0x00.
- dbg_disp_o, registered with one-cycle latency:
  - sel 0: FIFO count
  - sel 1: {5'b0, state}
  - sel 2: current tx byte
  - sel 3: digit index
  - sel 4: words-printed counter
  - sel 5: {7'b0, overflow_o}
  - sel 6-15: 0x00

Optional Feature:
PRINT_PREFIX_EN:
- Defined: each word is preceded by '0' (0x30) and 'x' (0x78) before the hex digits, giving DATA_W/4+4 characters per word.
- Undefined: no prefix, giving DATA_W/4+2 characters per word.
- All other behaviour is identical.

Test Plan:
- Case: BAUD_PER=10, DATA_W=16, macro off. Reset, then push 0x1A2F -> decoded bytes 31 41 32 46 0D 0A; start bit at edge k+3; busy_o falls 6*102+1 cycles after the start bit; words counter = 1.
- Case: push 0x0000 -> 30 30 30 30 0D 0A (leading zeros kept). Push 0xFFFF -> 46 46 46 46 0D 0A.
- Case: with printer busy, push 9 words (DEPTH=8) -> ready_o low after the 8th FIFO entry; the 9th is dropped; overflow_o=1. Exactly 9 words are printed in order (1 in flight + 8 queued) if the push of the 9th coincides with the first pop; otherwise 8. Check against count.
- Case: assert rst_i during the DATA bit of the 2nd character -> uarttx_ser_o=1 combinationally, FIFO empty, busy_o=0. A new push of 0x00FF then prints 30 30 46 46 0D 0A cleanly.
- Case: dbg_sel_i sweep 0..15 during printing -> values match FIFO count, state, tx byte, index, counter, overflow; sels 6-15 give 0x00.
- Case: PRINT_PREFIX_EN defined, push 0xBEEF -> 30 78 42 45 45 46 0D 0A.

Source files
------------

// File: rtl/uart_hex_printer.sv
// uart_hex_printer: buffers DATA_W-bit words in a small FIFO, renders each
// word as uppercase ASCII hex (MSB nibble first, leading zeros kept), appends
// CR LF, and sends the characters on an 8N1 UART line.
//
// Optional build macro PRINT_PREFIX_EN: when defined, every word is preceded
// by the characters '0' 'x'.
//
// Ports:
//   clk_100MHz    system clock
//   rst_i         asynchronous active-high reset
//   data_i        word to print
//   valid_i       word-valid strobe; push when valid_i && ready_o
//   ready_o       FIFO not full
//   uarttx_ser_o  UART serial output, idles high
//   busy_o        work pending (FIFO non-empty or printer active)
//   overflow_o    sticky: a word was offered while the FIFO was full
//   dbg_sel_i     debug display select
//   dbg_disp_o    debug display value (one-cycle latency)
module uart_hex_printer #(
  parameter int unsigned BAUD_PER   = 868,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk_100MHz,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              uarttx_ser_o,
  output logic              busy_o,
  output logic              overflow_o,
  input  logic [3:0]        dbg_sel_i,
  output logic [7:0]        dbg_disp_o
);

  localparam int unsigned NDIG   = DATA_W / 4;
  localparam int unsigned IDX_W  = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(BAUD_PER);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_NEXT  = 3'd5;

  // Which part of the per-word character sequence is being sent
  localparam logic [2:0] PH_PFX0 = 3'd0;
  localparam logic [2:0] PH_PFX1 = 3'd1;
  localparam logic [2:0] PH_HEX  = 3'd2;
  localparam logic [2:0] PH_CR   = 3'd3;
  localparam logic [2:0] PH_LF   = 3'd4;

`ifdef PRINT_PREFIX_EN
  localparam logic [2:0] PH_FIRST = PH_PFX0;
`else
  localparam logic [2:0] PH_FIRST = PH_HEX;
`endif

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              nempty_q, nempty_d;
  logic              idle_q, idle_d;
  logic              ready_q, ready_d;
  logic              overflow_q, overflow_d;
  logic              busy_q, busy_d;
  logic              line_q, line_d;
  logic [7:0]        dbg_q, dbg_d;

  logic [2:0]        state_q, state_d;
  logic [2:0]        phase_q, phase_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [7:0]        tx_q, tx_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        words_q, words_d;

  logic              push, pop, baud_done;
  logic [3:0]        nib;
  logic [7:0]        char_sel;

  assign push      = valid_i && ready_q;
  // Pop decision uses the registered non-empty flag, so a fresh word waits one cycle
  assign pop       = (state_q == ST_IDLE) && nempty_q;
  assign baud_done = (baud_q == BAUD_W'(BAUD_PER - 1));
  assign nib       = sh_q[DATA_W-1 -: 4];

  // Character for the current sequence position
  always_comb begin
    char_sel = 8'h0A;
    unique case (phase_q)
      PH_PFX0: char_sel = 8'h30;
      PH_PFX1: char_sel = 8'h78;
      PH_HEX:  char_sel = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
      PH_CR:   char_sel = 8'h0D;
      default: char_sel = 8'h0A;
    endcase
  end

  // FIFO bookkeeping and status flags
  always_comb begin
    wr_ptr_d   = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d   = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    count_d    = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ready_d    = (count_d != CNT_W'(FIFO_DEPTH));
    overflow_d = overflow_q | (valid_i & ~ready_q);
    nempty_d   = (count_q != '0);
    idle_d     = (state_q == ST_IDLE);
    busy_d     = nempty_q | ~idle_q;
  end

  // Printer FSM next state
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    baud_d  = baud_q + BAUD_W'(1);
    bit_d   = bit_q;
    words_d = words_q;
    unique case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (nempty_q) begin
          sh_d    = mem_q[rd_ptr_q];
          idx_d   = IDX_W'(NDIG - 1);
          phase_d = PH_FIRST;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        baud_d  = '0;
        tx_d    = char_sel;
        state_d = ST_START;
      end
      ST_START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        baud_d  = '0;
        state_d = ST_LOAD;
        unique case (phase_q)
          PH_PFX0: phase_d = PH_PFX1;
          PH_PFX1: phase_d = PH_HEX;
          PH_HEX: begin
            if (idx_q != '0) begin
              idx_d = idx_q - IDX_W'(1);
              sh_d  = sh_q << 4;
            end else begin
              phase_d = PH_CR;
            end
          end
          PH_CR:   phase_d = PH_LF;
          default: begin
            words_d = words_q + 8'd1;
            state_d = ST_IDLE;
          end
        endcase
      end
      default: begin
        baud_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Serial line follows the next state so it changes on the state-entry edge
  always_comb begin
    line_d = 1'b1;
    if (state_d == ST_START)     line_d = 1'b0;
    else if (state_d == ST_DATA) line_d = tx_d[bit_d];
  end

  // Debug display mux
  always_comb begin
    dbg_d = 8'h00;
    unique case (dbg_sel_i)
      4'd0:    dbg_d = 8'(count_q);
      4'd1:    dbg_d = {5'b0, state_q};
      4'd2:    dbg_d = tx_q;
      4'd3:    dbg_d = 8'(idx_q);
      4'd4:    dbg_d = words_q;
      4'd5:    dbg_d = {7'b0, overflow_q};
      default: dbg_d = 8'h00;
    endcase
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk_100MHz) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_100MHz or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      nempty_q   <= 1'b0;
      idle_q     <= 1'b1;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      line_q     <= 1'b1;
      dbg_q      <= 8'h00;
      state_q    <= ST_IDLE;
      phase_q    <= PH_FIRST;
      idx_q      <= '0;
      sh_q       <= '0;
      tx_q       <= 8'h00;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      words_q    <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      nempty_q   <= nempty_d;
      idle_q     <= idle_d;
      ready_q    <= ready_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      line_q     <= line_d;
      dbg_q      <= dbg_d;
      state_q    <= state_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      words_q    <= words_d;
    end
  end

  assign ready_o      = ready_q;
  assign uarttx_ser_o = line_q;
  assign busy_o       = busy_q;
  assign overflow_o   = overflow_q;
  assign dbg_disp_o   = dbg_q;

endmodule

// File: tb/tb_uart_hex_printer.sv
// Testbench for uart_hex_printer (BAUD_PER=10, DATA_W=16, FIFO_DEPTH=8).
// Expected characters are queued when a word is offered; a UART receiver
// process decodes the serial line and compares each byte against the queue.
`timescale 1ns/1ps
module tb_uart_hex_printer;

  localparam int unsigned B     = 10;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;
`ifdef PRINT_PREFIX_EN
  localparam int unsigned NCH = 8;
`else
  localparam int unsigned NCH = 6;
`endif
  localparam int unsigned CHAR_CYC = 10 * B + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready, ser, busy, ovf;
  logic [3:0]    sel;
  logic [7:0]    disp;

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  int unsigned   cyc = 0;
  logic [7:0]    exp_q[$];

  uart_hex_printer #(.BAUD_PER(B), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_100MHz  (clk),
    .rst_i       (rst),
    .data_i      (data),
    .valid_i     (valid),
    .ready_o     (ready),
    .uarttx_ser_o(ser),
    .busy_o      (busy),
    .overflow_o  (ovf),
    .dbg_sel_i   (sel),
    .dbg_disp_o  (disp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Queue the characters one word should produce
  task automatic exp_word(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
`ifdef PRINT_PREFIX_EN
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h78);
`endif
    exp_q.push_back(d0);
    exp_q.push_back(d1);
    exp_q.push_back(d2);
    exp_q.push_back(d3);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // One-cycle valid pulse; returns at the negedge after the sampling edge
  task automatic push_word(input logic [DW-1:0] w, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3, input bit accepted);
    @(negedge clk);
    data  = w;
    valid = 1'b1;
    if (accepted) exp_word(d0, d1, d2, d3);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_start(output int unsigned s);
    bit found = 0;
    s = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (ser === 1'b0) begin
        found = 1;
        s = cyc;
      end
    end
    check("start_bit_seen", 32'(found), 32'd1);
  endtask

  task automatic wait_busy_fall(output int unsigned t);
    bit found = 0;
    t = 0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 20000 && !found; i++) begin
      if (busy === 1'b0) begin
        found = 1;
        t = cyc;
      end else begin
        @(negedge clk);
      end
    end
    check("busy_fall_seen", 32'(found), 32'd1);
  endtask

  task automatic check_dbg(input string name, input logic [3:0] s, input logic [7:0] req);
    sel = s;
    @(negedge clk);
    check(name, 32'(disp), 32'(req));
  endtask

  function automatic logic [7:0] sweep_exp(input int s);
    case (s)
      0:       return 8'd8;    // FIFO full
      1:       return 8'd3;    // DATA state
      2:       return 8'h30;   // first character of 0x0000 (also the prefix '0')
      3:       return 8'd3;    // top digit index
      4:       return 8'd2;    // two words printed earlier
      5:       return 8'd1;    // overflow seen
      default: return 8'h00;
    endcase
  endfunction

  // UART receiver / scoreboard monitor
  initial begin : monitor
    bit          act = 0;
    int          cnt = 0;
    int          k;
    logic [7:0]  rx = 8'h00;
    logic [7:0]  e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        act = 0;
      end else if (!act) begin
        if (ser === 1'b0) begin
          act = 1;
          cnt = 0;
        end
      end else begin
        cnt++;
        if (cnt == B / 2) begin
          check("rx_start_mid", 32'(ser), 32'd0);
          if (ser !== 1'b0) act = 0;
        end else if (cnt > B / 2 && ((cnt - B / 2) % B) == 0) begin
          k = (cnt - B / 2) / B - 1;
          if (k < 8) begin
            rx[k] = ser;
          end else begin
            check("rx_stop_bit", 32'(ser), 32'd1);
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL rx_unexpected: got 0x%02h, expected no byte", rx);
            end else begin
              e = exp_q.pop_front();
              check("rx_byte", 32'(rx), 32'(e));
            end
            act = 0;
          end
        end
      end
    end
  end

  initial begin : driver
    int unsigned k, s, t;
    rst   = 1'b1;
    valid = 1'b0;
    data  = '0;
    sel   = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_line", 32'(ser), 32'd1);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_dbg", 32'(disp), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single word: latency, frame length, words counter
    push_word(16'h1A2F, 8'h31, 8'h41, 8'h32, 8'h46, 1);
    k = cyc;
    wait_start(s);
    check("start_latency", s - k, 32'd3);
    wait_busy_fall(t);
    check("busy_fall_time", t - s, NCH * CHAR_CYC + 1);
    check_dbg("words_after_1", 4'd4, 8'd1);
    sel = 4'd0;

    push_word(16'hBEEF, 8'h42, 8'h45, 8'h45, 8'h46, 1);
    wait_busy_fall(t);

    // Fill the FIFO behind an in-flight word; the 9th offer is dropped
    push_word(16'h0000, 8'h30, 8'h30, 8'h30, 8'h30, 1);
    wait_start(s);
    push_word(16'hFFFF, 8'h46, 8'h46, 8'h46, 8'h46, 1);
    push_word(16'h1234, 8'h31, 8'h32, 8'h33, 8'h34, 1);
    push_word(16'h5678, 8'h35, 8'h36, 8'h37, 8'h38, 1);
    push_word(16'h9ABC, 8'h39, 8'h41, 8'h42, 8'h43, 1);
    push_word(16'hDEF0, 8'h44, 8'h45, 8'h46, 8'h30, 1);
    push_word(16'h0001, 8'h30, 8'h30, 8'h30, 8'h31, 1);
    push_word(16'h8000, 8'h38, 8'h30, 8'h30, 8'h30, 1);
    push_word(16'hC3A5, 8'h43, 8'h33, 8'h41, 8'h35, 1);
    check("ready_low_full", 32'(ready), 32'd0);
    check("ovf_before_drop", 32'(ovf), 32'd0);
    push_word(16'h7777, 8'h37, 8'h37, 8'h37, 8'h37, 0);
    check("ovf_after_drop", 32'(ovf), 32'd1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) check_dbg($sformatf("dbg_sel_%0d", i), 4'(i), sweep_exp(i));
    sel = 4'd0;
    wait_busy_fall(t);
    check_dbg("words_after_11", 4'd4, 8'd11);
    check_dbg("fifo_drained", 4'd0, 8'd0);
    check("ovf_sticky", 32'(ovf), 32'd1);

    // Reset during bit 0 (a zero) of the second character
    push_word(16'h1234, 8'h31, 8'h32, 8'h33, 8'h34, 1);
    wait_start(s);
    repeat (CHAR_CYC + B + 3) @(negedge clk);
    check("line_low_pre_rst", 32'(ser), 32'd0);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("line_high_on_rst", 32'(ser), 32'd1);
    check("busy_clr_on_rst", 32'(busy), 32'd0);
    check("ready_on_rst", 32'(ready), 32'd1);
    check("ovf_clr_on_rst", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_dbg("fifo_empty_after_rst", 4'd0, 8'd0);
    check_dbg("idle_after_rst", 4'd1, 8'd0);

    push_word(16'h00FF, 8'h30, 8'h30, 8'h46, 8'h46, 1);
    wait_busy_fall(t);
    check_dbg("words_after_rst", 4'd4, 8'd1);
    check("all_bytes_seen", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
